mem_stage: RTL

Memory-access stage of the 5-stage MIPS pipeline, sitting between the EX/MEM pipeline register and the MEM/WB register. It issues loads and stores to the data memory over a req/gnt/rvalid handshake with variable latency. It stalls the upstream pipeline while an access is outstanding and resolves branches and jumps, driving the PC-select and flush signals. It forwards results and writeback controls to MEM/WB, inserting a bubble (RegWrite forced low) on every stalled cycle.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mem_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: memory-stage FSM states,
// default bus widths and the register-index width.
package mips_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int REG_IDX_W  = 5;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_WAIT_R = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// MIPS memory-access stage: data-memory req/gnt/rvalid handshake, pipeline stall,
// branch/jump resolution. Optional MEM_MISALIGN_CHECK_EN suppresses unaligned accesses.
module mem_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    alu_result_in,
  input  logic [DATA_W-1:0]    read_data2_in,
  input  logic [31:0]          branch_target_in,
  input  logic                 zero_in,
  input  logic                 branch_in,
  input  logic                 jump_in,
  input  logic [REG_IDX_W-1:0] write_reg_in,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic                 memto_reg_in,
  input  logic                 reg_write_in,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_W-1:0]    dmem_addr,
  output logic [DATA_W-1:0]    dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [DATA_W-1:0]    dmem_rdata,
  output logic                 mem_stall,
  output logic                 pc_src,
  output logic [31:0]          branch_target_out,
  output logic                 flush_out,
  output logic [DATA_W-1:0]    load_data_out,
  output logic [31:0]          alu_result_out,
  output logic [REG_IDX_W-1:0] write_reg_out,
  output logic                 memto_reg_out,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic                 misalign_err,
`endif
  output logic                 reg_write_out
);

  mem_state_t state, state_next;
  logic       mem_op;
  logic       misaligned;
  logic       access;

  assign mem_op = mem_read_in | mem_write_in;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = mem_op & (alu_result_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign access = mem_op & ~misaligned;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= MEM_IDLE;
    else          state <= state_next;
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset_n) misalign_err <= 1'b0;
    else          misalign_err <= (state == MEM_IDLE) & misaligned;
  end
`endif

  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise an uncovered path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      // Only a granted load needs to wait; a store with both read and write set is a store.
      MEM_IDLE:   if (access && dmem_gnt && !mem_write_in) state_next = MEM_WAIT_R;
      MEM_WAIT_R: if (dmem_rvalid) state_next = MEM_IDLE;
      default:    state_next = MEM_IDLE;
    endcase
  end

  always_comb begin
    dmem_req          = 1'b0;
    dmem_we           = 1'b0;
    dmem_addr         = '0;
    dmem_wdata        = '0;
    mem_stall         = 1'b0;
    pc_src            = 1'b0;
    flush_out         = 1'b0;
    branch_target_out = '0;
    load_data_out     = '0;
    alu_result_out    = '0;
    write_reg_out     = '0;
    memto_reg_out     = 1'b0;
    reg_write_out     = 1'b0;
    // Outputs stay quiet for the whole reset window, not just after the edge.
    if (reset_n) begin
      case (state)
        MEM_IDLE: begin
          dmem_req  = access;
          mem_stall = access & ~(dmem_gnt & mem_write_in);
        end
        MEM_WAIT_R: begin
          mem_stall = ~dmem_rvalid;
          if (dmem_rvalid) load_data_out = dmem_rdata;
        end
        default: ;
      endcase
      if (dmem_req) begin
        dmem_we    = mem_write_in;
        dmem_addr  = alu_result_in;
        dmem_wdata = read_data2_in;
      end
      pc_src            = (branch_in & zero_in) | jump_in;
      flush_out         = pc_src;
      branch_target_out = branch_target_in;
      alu_result_out    = 32'(alu_result_in);
      write_reg_out     = write_reg_in;
      memto_reg_out     = memto_reg_in;
      // Stalled cycles and suppressed unaligned ops reach MEM/WB as bubbles.
      reg_write_out     = reg_write_in & ~mem_stall & ~((state == MEM_IDLE) & misaligned);
    end
  end

endmodule
